// File: rtl/player_pkg.sv
// Shared sizing constants and types for the player register bank.
package player_pkg;

  localparam int NUM_CARDS = 5;
  localparam int CARD_W    = 6;
  localparam int CHIP_W    = 8;

  localparam logic [2:0] CHIP_SEL = 3'd5;

  typedef logic [CARD_W-1:0] card_t;

endpackage

// File: rtl/bank_cell.sv
// Parameterised-width storage register with load enable and async active-low clear.
module bank_cell #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/player_bank.sv
// Player card and chip registers: single-register writes by address plus a
// parallel card load that takes priority over single card writes.
module player_bank
  import player_pkg::*;
#(
  parameter int NUM_CARDS = player_pkg::NUM_CARDS,
  parameter int CARD_W    = player_pkg::CARD_W,
  parameter int CHIP_W    = player_pkg::CHIP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              enable_all,
  input  logic [2:0]        sel,
  input  logic [CHIP_W-1:0] data,
  input  logic [CARD_W-1:0] in_card  [NUM_CARDS],
  output logic [CARD_W-1:0] card_reg [NUM_CARDS],
  output logic [CHIP_W-1:0] chip_reg
);

  logic chip_load;

  // Parallel load claims every card, so a single card write on the same edge is dropped.
  for (genvar i = 0; i < NUM_CARDS; i++) begin : g_card
    logic              card_load;
    logic [CARD_W-1:0] card_next;

    assign card_load = enable_all | (enable & (sel == 3'(i)));
    assign card_next = enable_all ? in_card[i] : data[CARD_W-1:0];

    bank_cell #(.W(CARD_W)) u_card (
      .clk   (clk),
      .reset (reset),
      .load  (card_load),
      .d     (card_next),
      .q     (card_reg[i])
    );
  end

  // Chip writes are independent of the parallel card load.
  assign chip_load = enable & (sel == CHIP_SEL);

  bank_cell #(.W(CHIP_W)) u_chip (
    .clk   (clk),
    .reset (reset),
    .load  (chip_load),
    .d     (data),
    .q     (chip_reg)
  );

endmodule

// File: tb/tb_player_bank.sv
// Directed self-checking bench for player_bank.
module tb_player_bank;
  import player_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        enable_all;
  logic [2:0]  sel;
  logic [7:0]  data;
  card_t       in_card  [5];
  card_t       card_reg [5];
  logic [7:0]  chip_reg;

  card_t       exp_card [5];
  logic [7:0]  exp_chip;
  int          checks;
  int          errors;

  player_bank dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .enable_all (enable_all),
    .sel        (sel),
    .data       (data),
    .in_card    (in_card),
    .card_reg   (card_reg),
    .chip_reg   (chip_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      enable     = 1'($urandom);
      enable_all = 1'($urandom);
      sel        = 3'($urandom);
      data       = 8'($urandom);
      for (int i = 0; i < 5; i++) in_card[i] = 6'($urandom);
      tick();
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (card_reg[i] !== 6'd0) begin
          errors++;
          $display("FAIL reset_hold card_reg[%0d] got %0h expected 0", i, card_reg[i]);
        end
      end
      checks++;
      if (chip_reg !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold chip_reg got %0h expected 0", chip_reg);
      end
    end
    reset      = 1'b1;
    enable     = 1'b1;
    enable_all = 1'b0;
    sel        = 3'd0;
    data       = 8'd3;
    tick();
    enable = 1'b0;
    checks++;
    if (card_reg[0] !== 6'd3) begin
      errors++;
      $display("FAIL first_write card_reg[0] got %0h expected 3", card_reg[0]);
    end
    checks++;
    if (chip_reg !== 8'd0) begin
      errors++;
      $display("FAIL first_write chip_reg got %0h expected 0", chip_reg);
    end
  endtask

  task automatic test_sequential_write();
    enable     = 1'b1;
    enable_all = 1'b0;
    data       = 8'd15;
    for (int s = 0; s < 6; s++) begin
      sel = 3'(s);
      tick();
      if (s < 5) begin
        checks++;
        if (card_reg[s] !== 6'd15) begin
          errors++;
          $display("FAIL seq_write card_reg[%0d] got %0h expected f", s, card_reg[s]);
        end
        checks++;
        if (chip_reg !== 8'd0) begin
          errors++;
          $display("FAIL seq_write chip_reg early got %0h expected 0", chip_reg);
        end
      end else begin
        checks++;
        if (chip_reg !== 8'd15) begin
          errors++;
          $display("FAIL seq_write chip_reg got %0h expected f", chip_reg);
        end
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) exp_card[i] = 6'd15;
    exp_chip = 8'd15;
  endtask

  task automatic test_truncation();
    enable = 1'b1;
    sel    = 3'd2;
    data   = 8'hFF;
    tick();
    enable      = 1'b0;
    exp_card[2] = 6'h3F;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (card_reg[i] !== exp_card[i]) begin
        errors++;
        $display("FAIL truncation card_reg[%0d] got %0h expected %0h", i, card_reg[i], exp_card[i]);
      end
    end
    checks++;
    if (chip_reg !== exp_chip) begin
      errors++;
      $display("FAIL truncation chip_reg got %0h expected %0h", chip_reg, exp_chip);
    end
  endtask

  task automatic test_parallel_load();
    enable     = 1'b0;
    enable_all = 1'b1;
    for (int i = 0; i < 5; i++) in_card[i] = 6'd15;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (card_reg[i] !== 6'd15) begin
        errors++;
        $display("FAIL parallel_15 card_reg[%0d] got %0h expected f", i, card_reg[i]);
      end
    end
    for (int i = 0; i < 5; i++) in_card[i] = 6'(10 + i);
    tick();
    enable_all = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_card[i] = 6'(10 + i);
      checks++;
      if (card_reg[i] !== exp_card[i]) begin
        errors++;
        $display("FAIL parallel_idx card_reg[%0d] got %0h expected %0h", i, card_reg[i], exp_card[i]);
      end
    end
    checks++;
    if (chip_reg !== exp_chip) begin
      errors++;
      $display("FAIL parallel chip_reg got %0h expected %0h", chip_reg, exp_chip);
    end
  endtask

  task automatic test_priority();
    enable     = 1'b1;
    enable_all = 1'b1;
    sel        = 3'd1;
    data       = 8'd7;
    for (int i = 0; i < 5; i++) in_card[i] = 6'(20 + i);
    in_card[1] = 6'd9;
    tick();
    enable     = 1'b0;
    enable_all = 1'b0;
    for (int i = 0; i < 5; i++) exp_card[i] = 6'(20 + i);
    exp_card[1] = 6'd9;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (card_reg[i] !== exp_card[i]) begin
        errors++;
        $display("FAIL priority card_reg[%0d] got %0h expected %0h", i, card_reg[i], exp_card[i]);
      end
    end
    checks++;
    if (chip_reg !== exp_chip) begin
      errors++;
      $display("FAIL priority chip_reg got %0h expected %0h", chip_reg, exp_chip);
    end
  endtask

  task automatic test_chip_with_parallel();
    enable     = 1'b1;
    enable_all = 1'b1;
    sel        = 3'd5;
    data       = 8'hA5;
    for (int i = 0; i < 5; i++) in_card[i] = 6'(30 + i);
    tick();
    enable     = 1'b0;
    enable_all = 1'b0;
    for (int i = 0; i < 5; i++) exp_card[i] = 6'(30 + i);
    exp_chip = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (card_reg[i] !== exp_card[i]) begin
        errors++;
        $display("FAIL chip_parallel card_reg[%0d] got %0h expected %0h", i, card_reg[i], exp_card[i]);
      end
    end
    checks++;
    if (chip_reg !== exp_chip) begin
      errors++;
      $display("FAIL chip_parallel chip_reg got %0h expected %0h", chip_reg, exp_chip);
    end
  endtask

  task automatic test_hold_and_unused_sel();
    enable     = 1'b0;
    enable_all = 1'b0;
    sel        = 3'd5;
    data       = 8'h3C;
    for (int i = 0; i < 5; i++) in_card[i] = 6'd1;
    tick();
    enable = 1'b1;
    sel    = 3'd6;
    data   = 8'h11;
    tick();
    sel  = 3'd7;
    data = 8'h22;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (card_reg[i] !== exp_card[i]) begin
        errors++;
        $display("FAIL hold_unused card_reg[%0d] got %0h expected %0h", i, card_reg[i], exp_card[i]);
      end
    end
    checks++;
    if (chip_reg !== exp_chip) begin
      errors++;
      $display("FAIL hold_unused chip_reg got %0h expected %0h", chip_reg, exp_chip);
    end
  endtask

  task automatic test_async_reset();
    enable     = 1'b1;
    enable_all = 1'b1;
    sel        = 3'd5;
    data       = 8'h5A;
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (card_reg[i] !== 6'd0) begin
        errors++;
        $display("FAIL async_reset card_reg[%0d] got %0h expected 0", i, card_reg[i]);
      end
    end
    checks++;
    if (chip_reg !== 8'd0) begin
      errors++;
      $display("FAIL async_reset chip_reg got %0h expected 0", chip_reg);
    end
    tick();
    checks++;
    if (chip_reg !== 8'd0 || card_reg[0] !== 6'd0) begin
      errors++;
      $display("FAIL reset_blocks_write chip_reg got %0h card_reg[0] got %0h expected 0 and 0",
               chip_reg, card_reg[0]);
    end
    enable     = 1'b0;
    enable_all = 1'b0;
    reset      = 1'b1;
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    enable     = 1'b0;
    enable_all = 1'b0;
    sel        = 3'd0;
    data       = 8'd0;
    for (int i = 0; i < 5; i++) begin
      in_card[i]  = 6'd0;
      exp_card[i] = 6'd0;
    end
    exp_chip = 8'd0;
    #1;
    test_reset();
    test_sequential_write();
    test_truncation();
    test_parallel_load();
    test_priority();
    test_chip_with_parallel();
    test_hold_and_unused_sel();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_bank.md
PLAYER_BANK -- requirements
Module: player_bank

Interface
REQ-001 Parameter NUM_CARDS, default 5: number of card registers.
REQ-002 Parameter CARD_W, default 6: card register width in bits.
REQ-003 Parameter CHIP_W, default 8: chip register width; also the width of data.
REQ-004 clk  input  1: single system clock; all registers update on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset; asserted when 0.
REQ-006 enable  input  1: single-register write strobe.
REQ-007 enable_all  input  1: parallel card-load strobe.
REQ-008 sel  input  3: write address; 0..4 select card_reg[0..4], 5 selects chip_reg, 6..7 unused.
REQ-009 data  input  CHIP_W: write data for a single-register write.
REQ-010 in_card  input  unpacked array [NUM_CARDS] of CARD_W: parallel card load values.
REQ-011 card_reg  output  unpacked array [NUM_CARDS] of CARD_W: player card registers.
REQ-012 chip_reg  output  CHIP_W: player chip count register.

Function
REQ-013 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-014 When enable=1, enable_all=0 and sel<NUM_CARDS, card_reg[sel] SHALL load data[CARD_W-1:0] on the next rising edge; upper data bits are discarded.
REQ-015 When enable=1 and sel=5, chip_reg SHALL load data on the next rising edge.
REQ-016 When enable=1 and sel is 6 or 7, no register SHALL change.
REQ-017 When enable_all=1, every card_reg[i] SHALL load in_card[i] on the next rising edge.
REQ-018 When enable_all=1 and enable=1 with sel<NUM_CARDS, the parallel load SHALL win and the single write is dropped.
REQ-019 When enable_all=1 and enable=1 with sel=5, the parallel card load and the chip_reg write SHALL both take effect on the same edge.
REQ-020 When enable=0 and enable_all=0, all registers SHALL hold their values.
REQ-021 Write latency SHALL be one clock; a written value SHALL be visible on the output immediately after the capturing edge.
REQ-022 X or Z on enable or enable_all SHALL be treated as 0 by the design intent; the bench SHALL drive both strobes to known values after reset.

Reset
REQ-023 While reset=0, all card_reg entries and chip_reg SHALL be 0 immediately, independent of clk.
REQ-024 Reset SHALL override any in-progress write; no write SHALL take effect on an edge where reset=0.
REQ-025 The first write after reset release SHALL occur on the first rising edge with reset=1.

Structure
REQ-026 A shared package player_pkg SHALL hold NUM_CARDS, CARD_W, CHIP_W, the chip select code CHIP_SEL=5, and a card_t typedef (logic [CARD_W-1:0]).
REQ-027 One sub-module bank_cell SHALL be used: a parameterised-width register with async active-low reset and a load enable, instantiated NUM_CARDS times for the cards and once for the chip register.
REQ-028 Write decode and priority logic SHALL reside in player_bank.

Verification
REQ-029 Hold reset=0 with random inputs, then release -> all card_reg entries and chip_reg equal 0 during reset.
REQ-030 enable=1, data=15, sel stepped 0..5 on successive edges -> card_reg[0..4]=15, then chip_reg=15.
REQ-031 enable=1, sel=2, data=8'hFF -> card_reg[2]=6'h3F; all other registers unchanged.
REQ-032 enable=0, enable_all=1, all in_card=15 -> every card_reg=15 after one edge; chip_reg unchanged.
REQ-033 enable=1, sel=1, data=7 together with enable_all=1, in_card[1]=9 -> card_reg[1]=9.
REQ-034 enable=1, sel=6 or 7 -> no register changes; then assert reset=0 between clock edges -> all outputs 0 immediately.
